decode_dispatch_queue: RTL and testbench

Consumer side of the decode-to-execute boundary: accepts decoded instruction bundles (opcode, funct fields, register indices, immediate, memory/writeback controls) under a valid/ready handshake and presents them in order to the rename/dispatch stage. It buffers up to DEPTH bundles so that back-pressure from dispatch (full reservation stations or ROB) does not drop decoded instructions. It supports a single-cycle flush for branch mispredict recovery.

---
 rtl/decode_dispatch_queue.sv | 191 +++++++++++++++++++
 tb/tb_decode_dispatch_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_queue.sv
// -----------------------------------------------------------------------------
// decode_dispatch_queue
//
// In-order bundle queue between decode and rename/dispatch. It holds up to
// DEPTH decoded instruction bundles so that dispatch back-pressure never drops
// a decoded instruction. A synchronous flush empties the queue in one cycle
// for branch-mispredict recovery.
//
// Optional feature macro: DISPATCH_BYPASS_EN
//   When defined, a bundle arriving at an empty queue is presented to dispatch
//   in the same cycle. If dispatch takes it, the bundle is never stored.
//   When undefined, a bundle is visible one cycle after it is accepted, and
//   there is no combinational path from the inputs to the outputs.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   flush                discard all stored bundles on the next edge
//   in_valid / in_ready  upstream handshake (in_ready depends on count only)
//   *_in                 decoded bundle fields (72 bits in total)
//   out_valid / out_ready  dispatch handshake
//   *_out                head bundle fields, all zero when out_valid=0
//   count                occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module decode_dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode_in,
  input  logic [2:0]       funct3_in,
  input  logic [6:0]       funct7_in,
  input  logic [4:0]       srcReg1_in,
  input  logic [4:0]       srcReg2_in,
  input  logic [4:0]       destReg_in,
  input  logic [31:0]      imm_in,
  input  logic [1:0]       lwSw_in,
  input  logic             regWrite_in,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  logic             memToReg_in,
  input  logic             hasImm_in,
  input  logic             storeSize_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       opcode_out,
  output logic [2:0]       funct3_out,
  output logic [6:0]       funct7_out,
  output logic [4:0]       srcReg1_out,
  output logic [4:0]       srcReg2_out,
  output logic [4:0]       destReg_out,
  output logic [31:0]      imm_out,
  output logic [1:0]       lwSw_out,
  output logic             regWrite_out,
  output logic             memRead_out,
  output logic             memWrite_out,
  output logic             memToReg_out,
  output logic             hasImm_out,
  output logic             storeSize_out,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [1:0]  lwsw;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        has_imm;
    logic        store_size;
  } bundle_t;

  bundle_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  bundle_t w_in_bundle;
  bundle_t w_head;
  bundle_t w_out;
  logic    w_full;
  logic    w_empty;
  logic    w_bypass;
  logic    w_push;
  logic    w_pop;

  // Incoming bundle, with regWrite cleared for writes to x0 so dispatch never
  // sees a register write that has no architectural effect.
  // NOTE: every always_comb output gets a value on every path (here a single
  // full assignment), otherwise synthesis infers a latch.
  always_comb begin
    w_in_bundle = '{
      opcode:     opcode_in,
      funct3:     funct3_in,
      funct7:     funct7_in,
      src1:       srcReg1_in,
      src2:       srcReg2_in,
      dest:       destReg_in,
      imm:        imm_in,
      lwsw:       lwSw_in,
      reg_write:  regWrite_in & (destReg_in != 5'd0),
      mem_read:   memRead_in,
      mem_write:  memWrite_in,
      mem_to_reg: memToReg_in,
      has_imm:    hasImm_in,
      store_size: storeSize_in
    };
  end

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // in_ready looks at the registered count only: a pop in this cycle does not
  // open a slot until the next cycle, which keeps out_ready off the upstream
  // timing path.
  assign in_ready = ~w_full;

`ifdef DISPATCH_BYPASS_EN
  assign w_bypass = w_empty & in_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid = ~w_empty | w_bypass;

  // A bypassed bundle taken by dispatch this cycle is not stored.
  assign w_push = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
  assign w_pop  = ~w_empty & out_ready & ~flush;

  always_comb begin
    w_head = w_bypass ? w_in_bundle : r_mem[r_rd_ptr];
    w_out  = out_valid ? w_head : '0;
  end

  assign opcode_out    = w_out.opcode;
  assign funct3_out    = w_out.funct3;
  assign funct7_out    = w_out.funct7;
  assign srcReg1_out   = w_out.src1;
  assign srcReg2_out   = w_out.src2;
  assign destReg_out   = w_out.dest;
  assign imm_out       = w_out.imm;
  assign lwSw_out      = w_out.lwsw;
  assign regWrite_out  = w_out.reg_write;
  assign memRead_out   = w_out.mem_read;
  assign memWrite_out  = w_out.mem_write;
  assign memToReg_out  = w_out.mem_to_reg;
  assign hasImm_out    = w_out.has_imm;
  assign storeSize_out = w_out.store_size;
  assign count         = r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the bundle array has no reset; entries are only observable after
  // being written, because out_valid and the output zeroing are count-driven.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_bundle;
  end

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_dispatch_queue
//
// Self-checking bench for decode_dispatch_queue. A queue-based reference model
// tracks stored bundles; one compare process checks count, in_ready,
// out_valid and the full output bundle on every falling edge. Directed
// sequences pin literal values; a long randomized phase with occasional
// flushes and one mid-run reset exercises the rest. Honours
// DISPATCH_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_decode_dispatch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [1:0]  lwsw;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        has_imm;
    logic        store_size;
  } bundle_t;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  logic in_valid;
  logic out_ready;
  bundle_t in_b;

  logic             in_ready;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [4:0]  srcReg1_out, srcReg2_out, destReg_out;
  logic [31:0] imm_out;
  logic [1:0]  lwSw_out;
  logic regWrite_out, memRead_out, memWrite_out, memToReg_out, hasImm_out, storeSize_out;

  bundle_t dut_b;
  assign dut_b = {opcode_out, funct3_out, funct7_out, srcReg1_out, srcReg2_out,
                  destReg_out, imm_out, lwSw_out, regWrite_out, memRead_out,
                  memWrite_out, memToReg_out, hasImm_out, storeSize_out};

  always #5 clk = ~clk;

  decode_dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode_in    (in_b.opcode),
    .funct3_in    (in_b.funct3),
    .funct7_in    (in_b.funct7),
    .srcReg1_in   (in_b.src1),
    .srcReg2_in   (in_b.src2),
    .destReg_in   (in_b.dest),
    .imm_in       (in_b.imm),
    .lwSw_in      (in_b.lwsw),
    .regWrite_in  (in_b.reg_write),
    .memRead_in   (in_b.mem_read),
    .memWrite_in  (in_b.mem_write),
    .memToReg_in  (in_b.mem_to_reg),
    .hasImm_in    (in_b.has_imm),
    .storeSize_in (in_b.store_size),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .opcode_out   (opcode_out),
    .funct3_out   (funct3_out),
    .funct7_out   (funct7_out),
    .srcReg1_out  (srcReg1_out),
    .srcReg2_out  (srcReg2_out),
    .destReg_out  (destReg_out),
    .imm_out      (imm_out),
    .lwSw_out     (lwSw_out),
    .regWrite_out (regWrite_out),
    .memRead_out  (memRead_out),
    .memWrite_out (memWrite_out),
    .memToReg_out (memToReg_out),
    .hasImm_out   (hasImm_out),
    .storeSize_out(storeSize_out),
    .count        (count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bundle_t m_q[$];

  function automatic bundle_t norm(input bundle_t b);
    bundle_t r = b;
    r.reg_write = b.reg_write & (b.dest != 5'd0);
    return r;
  endfunction

  // Model state: what has been accepted and not yet dispatched, oldest first.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
    end else if (flush) begin
      m_q.delete();
    end else begin
      automatic bit taken_direct = BYP && m_q.size() == 0 && in_valid && out_ready;
      automatic bit do_pop  = m_q.size() != 0 && out_ready;
      automatic bit do_push = in_valid && m_q.size() != DEPTH && !taken_direct;
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(norm(in_b));
    end
  end

  // Single compare process: every falling edge.
  always @(negedge clk) begin
    automatic int      n   = m_q.size();
    automatic bit      byp = BYP && n == 0 && in_valid && !flush;
    automatic bundle_t exp_b;
    if (byp)         exp_b = norm(in_b);
    else if (n != 0) exp_b = m_q[0];
    else             exp_b = '0;
    check("count",     72'(count),     72'(n));
    check("in_ready",  72'(in_ready),  72'(n != DEPTH));
    check("out_valid", 72'(out_valid), 72'((n != 0) || byp));
    check("bundle",    72'(dut_b),     72'(exp_b));
  end

  // ---------------- stimulus helpers ----------------
  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b = {$urandom(), $urandom(), 8'($urandom())};
    if ($urandom_range(0, 3) == 0) b.dest = 5'd0;
    return b;
  endfunction

  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic rw);
    bundle_t b = '0;
    b.opcode    = op;
    b.dest      = rd;
    b.imm       = imm;
    b.reg_write = rw;
    return b;
  endfunction

  // Drive one cycle's inputs just after the rising edge, return at the
  // following falling edge so callers can inspect the settled outputs.
  task automatic cycle(input bit v, input bundle_t b, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bundle_t b33;
    bundle_t seq[5];
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_b = '0;

    @(negedge clk);
    check("rst_count",    72'(count),     72'd0);
    check("rst_in_ready", 72'(in_ready),  72'd1);
    check("rst_out_valid",72'(out_valid), 72'd0);
    check("rst_fields",   72'(dut_b),     72'd0);
    rstn = 1'b1;

    // First push: visible the cycle after acceptance.
    b33 = mk(7'h33, 5'd5, 32'h10, 1'b1);
    cycle(1, b33, 0, 0);
    cycle(0, '0, 0, 0);
    check("push1_count",   72'(count),       72'd1);
    check("push1_valid",   72'(out_valid),   72'd1);
    check("push1_opcode",  72'(opcode_out),  72'h33);
    check("push1_dest",    72'(destReg_out), 72'd5);
    check("push1_imm",     72'(imm_out),     72'h10);
    check("model_size1",   72'(m_q.size()),  72'd1);

    // Fill to DEPTH, present a fifth.
    for (int i = 0; i < 5; i++) seq[i] = rnd_bundle();
    for (int i = 0; i < 3; i++) cycle(1, seq[i], 0, 0);
    cycle(1, seq[3], 0, 0);
    check("full_in_ready", 72'(in_ready), 72'd0);
    check("full_count",    72'(count),    72'd4);
    cycle(1, seq[3], 1, 0);
    check("full_pop_in_ready", 72'(in_ready), 72'd0);
    cycle(1, seq[3], 0, 0);
    check("after_pop_in_ready", 72'(in_ready),  72'd1);
    check("after_pop_count",    72'(count),     72'd3);
    check("after_pop_head",     72'(dut_b),     72'(norm(seq[0])));
    cycle(0, '0, 0, 1);

    // regWrite normalisation.
    cycle(1, mk(7'h13, 5'd0, 32'h1, 1'b1), 0, 0);
    cycle(1, mk(7'h13, 5'd3, 32'h2, 1'b1), 0, 0);
    cycle(0, '0, 0, 0);
    check("rw_x0",  72'(regWrite_out), 72'd0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    check("rw_x3",  72'(regWrite_out), 72'd1);

    // Flush from count=3 with push and pop requested.
    cycle(1, rnd_bundle(), 0, 0);
    cycle(1, rnd_bundle(), 0, 0);
    cycle(0, '0, 0, 0);
    check("pre_flush_count", 72'(count), 72'd3);
    cycle(1, rnd_bundle(), 1, 1);
    cycle(0, '0, 0, 0);
    check("flush_count",  72'(count),     72'd0);
    check("flush_valid",  72'(out_valid), 72'd0);
    check("flush_fields", 72'(dut_b),     72'd0);

    // Same-cycle bypass versus one-cycle latency.
    cycle(1, mk(7'h03, 5'd7, 32'hFFFF_FFF0, 1'b1), 1, 0);
    if (BYP) begin
      check("byp_valid", 72'(out_valid), 72'd1);
      check("byp_imm",   72'(imm_out),   72'hFFFF_FFF0);
    end else begin
      check("nobyp_valid0", 72'(out_valid), 72'd0);
    end
    cycle(0, '0, 0, 0);
    if (BYP) begin
      check("byp_count", 72'(count),     72'd0);
      check("byp_after", 72'(out_valid), 72'd0);
    end else begin
      check("nobyp_valid1", 72'(out_valid), 72'd1);
      check("nobyp_imm",    72'(imm_out),   72'hFFFF_FFF0);
    end
    cycle(0, '0, 0, 1);

    // Sustained push+pop from count=2 across pointer wrap.
    cycle(1, rnd_bundle(), 0, 0);
    cycle(1, rnd_bundle(), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, rnd_bundle(), 1, 0);
      check("stream_count", 72'(count), 72'd2);
    end
    cycle(0, '0, 0, 1);

    // Randomized phase.
    for (int i = 0; i < 2000; i++) begin
      automatic int  ord_bias = (i < 600) ? 3 : ((i < 1300) ? 1 : 2);
      automatic bit  v    = $urandom_range(0, 3) != 0;
      automatic bit  ordy = $urandom_range(0, 3) < ord_bias;
      automatic bit  fl   = $urandom_range(0, 39) == 0;
      if (i == 900) begin
        // Asynchronous reset in the middle of traffic.
        #2;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_b = '0;
        rstn = 1'b0;
        #1;
        check("midrst_count",    72'(count),     72'd0);
        check("midrst_in_ready", 72'(in_ready),  72'd1);
        check("midrst_valid",    72'(out_valid), 72'd0);
        @(negedge clk);
        #1 rstn = 1'b1;
      end
      cycle(v, rnd_bundle(), ordy, fl);
    end
    cycle(0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
